spi_slave: RTL and testbench
============================

# spi_slave

SPI peripheral-side controller: the responder to the team's SPI master (`spi_module`) across the SCK/SS/MOSI/MISO link. It receives serial frames from an external master, presents each completed word on a parallel valid/ready port, and shifts out a word preloaded by local logic. All link inputs are oversampled in the `i_sys_clk` domain; no logic is clocked by SCK.

## Interface
- `DATA_W`, 8: bits per word.
- `SYNC_STAGES`, 2: synchronizer depth for SCK, SS and MOSI (≥2).
- `i_sys_clk` in 1: system clock, all logic on its rising edge.
- `i_sys_rst` in 1: asynchronous, active-high reset.
- `i_SCK` in 1: serial clock from the master.
- `i_SS` in 1: slave select, active low.
- `i_MOSI` in 1: serial data from the master.
- `o_MISO` out 1: serial data to the master.
- `o_MISO_oe` out 1: MISO drive enable, high only while selected.
- `i_cpol` in 1: SCK idle level.
- `i_cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge.
- `i_lsb_first` in 1: bit order for both directions.
- `i_tx_data` in DATA_W: word to transmit.
- `i_tx_valid` in 1: `i_tx_data` offered.
- `o_tx_ready` out 1: one-entry TX holding register empty.
- `o_rx_data` out DATA_W: last received word.
- `o_rx_valid` out 1: `o_rx_data` pending.
- `i_rx_ready` in 1: consumer accepts `o_rx_data`.
- `o_busy` out 1: frame in progress (SS low, synchronized).
- `o_overrun` out 1: one-cycle pulse when an unaccepted RX word is overwritten.

## Operation
- Reset values: `o_MISO`=0, `o_MISO_oe`=0, `o_tx_ready`=1, `o_rx_data`=0, `o_rx_valid`=0, `o_busy`=0, `o_overrun`=0. The shift registers, bit counter and holding register are cleared. The state is IDLE.
- Leading edge: synchronized SCK leaves the `i_cpol` level. Trailing edge: SCK returns to it.
- FSM: IDLE→ACTIVE on a synchronized SS fall. ACTIVE→IDLE on a synchronized SS rise, from any bit position.
- `i_cpol`, `i_cpha` and `i_lsb_first` are latched on entry to ACTIVE. Changes during a frame are ignored.
- On entry to ACTIVE, and after each completed word while SS stays low:
  - TX shift register loads the holding register, which is then emptied (`o_tx_ready`→1).
  - If the holding register is empty, the shift register loads all zeros.
  - The first bit (MSB, or LSB if `i_lsb_first`) is driven on `o_MISO`.
- CPHA=0: sample MOSI on the leading edge, advance MISO on the trailing edge.
- CPHA=1: advance MISO on the leading edge, sample on the trailing edge. The first leading edge does not advance; the first bit stays driven.
- The bit counter runs 0..DATA_W-1. On the DATA_W-th sample:
  - `o_rx_data` is updated and `o_rx_valid` is set.
  - If `o_rx_valid` was already high and not accepted in that cycle, `o_overrun` pulses and the data is overwritten.
- `o_rx_valid` clears on the cycle `i_rx_valid`&`i_rx_ready`… specifically when `o_rx_valid`&`i_rx_ready` are both high, unless a new word completes in the same cycle. In that case it stays high with the new data, and no overrun is flagged.
- A holding-register write (`i_tx_valid`&`o_tx_ready`) and a reload in the same cycle: the reload takes the old (empty → zeros) contents, and the write is kept for the next word.
- SS rise mid-word: partial RX bits are discarded with no `o_rx_valid`. The counter resets and `o_MISO_oe` drops. The holding register is untouched.
- `o_MISO_oe` = ACTIVE. `o_MISO` is held at 0 in IDLE.

## Timing
- SCK high and low phases must each be ≥ SYNC_STAGES+2 `i_sys_clk` periods.
- SS-fall to first MISO bit valid: SYNC_STAGES+1 cycles.
- Pin SCK edge to MISO update: SYNC_STAGES+1 cycles.
- Last sampling edge at pin to `o_rx_valid` high: SYNC_STAGES+2 cycles.
- `o_tx_ready` falls the cycle after an accepted write.
- Reset mid-frame: the block returns to IDLE immediately, and the frame in progress is lost.

## Structure
- Package `spi_pkg`: state enum (IDLE, ACTIVE) and the default word width constant. Shared with the master.
- Sub-module `spi_sync`: SYNC_STAGES-deep flop synchronizer with reset value parameter. Three instances:
  - SS resets to 1.
  - SCK resets to 0.
  - MOSI resets to 0.

## Test plan
- Mode 0, MSB first, TX preload 0xA5, master sends 0x3C → `o_rx_data`=0x3C with one `o_rx_valid`; master reads 0xA5.
- Mode 3, LSB first, TX 0x81, master sends 0x7E → `o_rx_data`=0x7E; master reads 0x81; `o_MISO_oe` low after SS rise.
- Two back-to-back words under one SS low, no TX preload, `i_rx_ready`=0 → first 0x11 then 0x22, `o_overrun` one pulse, `o_rx_data`=0x22, master reads 0x00 twice.
- SS raised after 5 bits → no `o_rx_valid`. Next full frame with 0x5A → `o_rx_data`=0x5A, with no residue from the aborted frame.
- `i_sys_rst` asserted mid-frame in mode 1 → all outputs at reset values within 1 cycle. The next frame with 0xC3 is received correctly.
- `i_rx_ready` high in the same cycle a new word completes → `o_rx_valid` stays high with the new data, `o_overrun`=0.

Source files
------------

// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// spi_pkg : shared SPI link types and defaults (master and slave)
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// spi_sync : STAGES-deep flop synchronizer with selectable reset value
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// spi_slave : oversampled SPI peripheral with valid/ready RX and one-entry TX
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_SCK,
  input  logic              i_SS,
  input  logic              i_MOSI,
  output logic              o_MISO,
  output logic              o_MISO_oe,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int              CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  logic w_ss, w_sck, w_mosi;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_clk(i_sys_clk), .i_rst(i_sys_rst), .i_d(i_SS),   .o_q(w_ss));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk(i_sys_clk), .i_rst(i_sys_rst), .i_d(i_SCK),  .o_q(w_sck));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_sys_clk), .i_rst(i_sys_rst), .i_d(i_MOSI), .o_q(w_mosi));

  spi_state_e        r_state, w_state_nxt;
  logic              r_ss_d, r_sck_d;
  logic              r_cpol, r_cpha, r_lsb;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_tx_sh, r_rx_sh, r_rx_word, r_hold, r_rx_data;
  logic              r_hold_full, r_skip, r_done, r_rx_valid, r_overrun;

  logic w_ss_fall, w_ss_rise, w_active, w_enter, w_sck_edge, w_lead, w_trail;
  logic w_run, w_sample, w_shift, w_word_end, w_load, w_wr;
  logic [DATA_W-1:0] w_rx_next;

  assign w_ss_fall  = r_ss_d & ~w_ss;
  assign w_ss_rise  = ~r_ss_d & w_ss;
  assign w_active   = (r_state == ACTIVE);
  assign w_enter    = (r_state == IDLE) & w_ss_fall;
  assign w_sck_edge = w_sck ^ r_sck_d;
  assign w_lead     = w_sck_edge & (w_sck != r_cpol);
  assign w_trail    = w_sck_edge & (w_sck == r_cpol);
  assign w_run      = w_active & ~w_ss_rise;
  assign w_sample   = w_run & (r_cpha ? w_trail : w_lead);
  assign w_shift    = w_run & (r_cpha ? w_lead : w_trail);
  assign w_word_end = w_sample & (r_cnt == C_LAST);
  assign w_load     = w_enter | w_word_end;
  assign w_wr       = i_tx_valid & ~r_hold_full;
  assign w_rx_next  = r_lsb ? {w_mosi, r_rx_sh[DATA_W-1:1]}
                            : {r_rx_sh[DATA_W-2:0], w_mosi};

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_ss_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_ss_d      <= 1'b1;
      r_sck_d     <= 1'b0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsb       <= 1'b0;
      r_cnt       <= '0;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_rx_word   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_skip      <= 1'b0;
      r_done      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_ss_d  <= w_ss;
      r_sck_d <= w_sck;
      r_done  <= w_word_end;

      if (w_enter) begin
        r_cpol <= i_cpol;
        r_cpha <= i_cpha;
        r_lsb  <= i_lsb_first;
      end

      if (w_enter || (w_active && w_ss_rise)) begin
        r_cnt   <= '0;
        r_rx_sh <= '0;
      end else if (w_sample) begin
        r_cnt   <= w_word_end ? '0 : r_cnt + 1'b1;
        r_rx_sh <= w_rx_next;
      end

      if (w_word_end) r_rx_word <= w_rx_next;

      // The first shift edge after a load must leave the first bit on the
      // wire, except at frame start in CPHA=0 where the first shift edge
      // follows the first sample.
      if (w_load) begin
        r_tx_sh <= r_hold_full ? r_hold : '0;
        r_skip  <= w_enter ? i_cpha : 1'b1;
      end else if (w_shift) begin
        if (r_skip) r_skip  <= 1'b0;
        else        r_tx_sh <= r_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
      end

      if (w_wr) r_hold <= i_tx_data;
      if (w_load)    r_hold_full <= w_wr;
      else if (w_wr) r_hold_full <= 1'b1;

      r_overrun <= r_done & r_rx_valid & ~i_rx_ready;
      if (r_done) begin
        r_rx_data  <= r_rx_word;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_MISO     = w_active & (r_lsb ? r_tx_sh[0] : r_tx_sh[DATA_W-1]);
  assign o_MISO_oe  = w_active;
  assign o_busy     = w_active;
  assign o_tx_ready = ~r_hold_full;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_slave : bit-banged SPI master against spi_slave with word scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int W  = 8;
  localparam int HP = 6;

  logic         clk = 1'b0, rst = 1'b1;
  logic         sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic         miso, miso_oe;
  logic         cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0, tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, rx_ready = 1'b1;
  logic         busy, overrun;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] got_q[$];
  int           ovr_total = 0;
  logic [W-1:0] m_out [2];
  logic [W-1:0] m_in  [2];

  spi_slave #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_SCK(sck), .i_SS(ss), .i_MOSI(mosi),
    .o_MISO(miso), .o_MISO_oe(miso_oe), .i_cpol(cpol), .i_cpha(cpha),
    .i_lsb_first(lsb), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .i_rx_ready(rx_ready), .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (overrun) ovr_total++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int bit_pos(input int b);
    return lsb ? (b % W) : (W - 1 - (b % W));
  endfunction

  function automatic logic mo_bit(input int b);
    return m_out[b / W][bit_pos(b)];
  endfunction

  // Optional ready pulse timed so acceptance lands on the same cycle the
  // final word is delivered (SYNC_STAGES+2 cycles after the sampling edge).
  task automatic half(input bit pulse, input int b);
    if (pulse) begin
      step(3);
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
      chk("same_cyc_valid", rx_valid, 1);
      chk("same_cyc_data", rx_data, m_out[b / W]);
      step(HP - 4);
    end else begin
      step(HP);
    end
  endtask

  task automatic spi_xfer(input int mode, input bit lsbf, input int nbits, input bit rpulse);
    cpol = mode[1];
    cpha = mode[0];
    lsb  = lsbf;
    sck  = mode[1];
    m_in[0] = '0;
    m_in[1] = '0;
    step(HP);
    ss = 1'b0;
    if (!cpha) mosi = mo_bit(0);
    step(HP);
    chk("oe_on", miso_oe, 1);
    chk("busy_on", busy, 1);
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        sck = ~cpol;
        m_in[b / W][bit_pos(b)] = miso;
        half(rpulse && (b == nbits - 1), b);
        sck = cpol;
        if (b + 1 < nbits) mosi = mo_bit(b + 1);
        step(HP);
      end else begin
        sck  = ~cpol;
        mosi = mo_bit(b);
        step(HP);
        sck = cpol;
        m_in[b / W][bit_pos(b)] = miso;
        half(rpulse && (b == nbits - 1), b);
      end
    end
    ss = 1'b1;
    step(HP);
    chk("oe_off", miso_oe, 0);
    chk("busy_off", busy, 0);
  endtask

  task automatic tx_preload(input logic [W-1:0] d);
    chk("txrdy_pre", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    chk("txrdy_fall", tx_ready, 0);
  endtask

  task automatic chk_rx(input string tag, input int base, input int n);
    chk({tag, "_cnt"}, got_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      chk(tag, (got_q.size() > base + i) ? {24'd0, got_q[base + i]} : 32'hxxxx_xxxx,
          m_out[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, ob, mode, nw;
    bit lsbf, pre;
    logic [W-1:0] pd;

    rst = 1'b1;
    step(3);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_txrdy", tx_ready, 1);
    chk("rst_rxdata", rx_data, 0);
    chk("rst_rxvalid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    step(5);

    // Mode 0, MSB first
    tx_preload(8'hA5);
    m_out[0] = 8'h3C;
    base = got_q.size();
    spi_xfer(0, 1'b0, W, 1'b0);
    chk_rx("m0_rx", base, 1);
    chk("m0_miso", m_in[0], 8'hA5);

    // Mode 3, LSB first
    tx_preload(8'h81);
    m_out[0] = 8'h7E;
    base = got_q.size();
    spi_xfer(3, 1'b1, W, 1'b0);
    chk_rx("m3_rx", base, 1);
    chk("m3_miso", m_in[0], 8'h81);

    // Back-to-back words, consumer stalled
    rx_ready = 1'b0;
    ob = ovr_total;
    m_out[0] = 8'h11;
    m_out[1] = 8'h22;
    spi_xfer(0, 1'b0, 2 * W, 1'b0);
    chk("b2b_ovr", ovr_total - ob, 1);
    chk("b2b_data", rx_data, 8'h22);
    chk("b2b_valid", rx_valid, 1);
    chk("b2b_miso0", m_in[0], 0);
    chk("b2b_miso1", m_in[1], 0);
    rx_ready = 1'b1;
    step(2);
    chk("b2b_drain", rx_valid, 0);

    // Aborted frame then a clean one
    m_out[0] = 8'hFF;
    base = got_q.size();
    spi_xfer(0, 1'b0, 5, 1'b0);
    chk("abort_cnt", got_q.size() - base, 0);
    chk("abort_valid", rx_valid, 0);
    m_out[0] = 8'h5A;
    base = got_q.size();
    spi_xfer(0, 1'b0, W, 1'b0);
    chk_rx("post_abort", base, 1);

    // Reset in the middle of a mode 1 frame
    rx_ready = 1'b0;
    m_out[0] = 8'h77;
    spi_xfer(1, 1'b0, W, 1'b0);
    chk("pre_rst_valid", rx_valid, 1);
    cpol = 1'b0; cpha = 1'b1; lsb = 1'b0; sck = 1'b0;
    step(HP);
    ss = 1'b0;
    step(HP);
    for (int b = 0; b < 3; b++) begin
      sck = 1'b1; mosi = b[0]; step(HP);
      sck = 1'b0; step(HP);
    end
    tx_preload(8'h99);
    rst = 1'b1;
    #1;
    chk("mrst_miso", miso, 0);
    chk("mrst_oe", miso_oe, 0);
    chk("mrst_txrdy", tx_ready, 1);
    chk("mrst_rxdata", rx_data, 0);
    chk("mrst_rxvalid", rx_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovr", overrun, 0);
    step(2);
    ss = 1'b1;
    sck = 1'b0;
    step(4);
    rst = 1'b0;
    rx_ready = 1'b1;
    step(HP);
    m_out[0] = 8'hC3;
    base = got_q.size();
    spi_xfer(1, 1'b0, W, 1'b0);
    chk_rx("post_rst", base, 1);
    chk("post_rst_miso", m_in[0], 0);

    // Acceptance coinciding with delivery of a new word
    rx_ready = 1'b0;
    ob = ovr_total;
    m_out[0] = 8'h4D;
    m_out[1] = 8'hB2;
    spi_xfer(2, 1'b1, 2 * W, 1'b1);
    chk("same_cyc_ovr", ovr_total - ob, 0);
    chk("same_cyc_hold", rx_data, 8'hB2);
    rx_ready = 1'b1;
    step(2);

    // Randomized frames
    for (int k = 0; k < 20; k++) begin
      mode = $urandom_range(0, 3);
      lsbf = 1'($urandom_range(0, 1));
      nw   = $urandom_range(1, 2);
      pre  = 1'($urandom_range(0, 1));
      pd   = W'($urandom);
      m_out[0] = W'($urandom);
      m_out[1] = W'($urandom);
      if (pre) tx_preload(pd);
      base = got_q.size();
      spi_xfer(mode, lsbf, nw * W, 1'b0);
      chk_rx("rnd_rx", base, nw);
      chk("rnd_miso0", m_in[0], pre ? pd : '0);
      if (nw == 2) chk("rnd_miso1", m_in[1], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
